// File: rtl/elliptic_curve_structs.sv
// Shared constants for the ECDSA job loader: register map, status bit
// positions, loader state encoding and the status word packer.
package elliptic_curve_structs;

    localparam logic [3:0] ADDR_KEY_LAST  = 4'd7;
    localparam logic [3:0] ADDR_MSG_FIRST = 4'd8;
    localparam logic [3:0] ADDR_MSG_MID   = 4'd9;
    localparam logic [3:0] ADDR_MSG_LAST  = 4'd10;
    localparam logic [3:0] ADDR_COUNT     = 4'd12;
    localparam logic [3:0] ADDR_START     = 4'd14;
    localparam logic [3:0] ADDR_STATUS    = 4'd15;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_INVALID = 2;
    localparam int STAT_TIMEOUT = 3;
    localparam int STAT_WR_ERR  = 4;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_RUN  = 2'd1,
        LD_DONE = 2'd2
    } loader_state_e;

    function automatic logic [31:0] pack_status(input logic busy, input logic done,
                                                input logic invalid, input logic timeout,
                                                input logic wr_err);
        logic [31:0] word;
        word               = 32'd0;
        word[STAT_BUSY]    = busy;
        word[STAT_DONE]    = done;
        word[STAT_INVALID] = invalid;
        word[STAT_TIMEOUT] = timeout;
        word[STAT_WR_ERR]  = wr_err;
        return word;
    endfunction

endpackage

// File: rtl/job_cycle_counter.sv
// Saturating 32-bit job cycle counter; clear has priority over enable.
module job_cycle_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count
);

    // count RUN cycles, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 32'd0;
        end else if (clr) begin
            count <= 32'd0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/ecdsa_job_loader.sv
// Register front-end that loads key/message operands, launches and times an
// ECDSA core job. Optional RUN timeout enabled by defining ECDSA_JOB_TIMEOUT_EN.
module ecdsa_job_loader
    import elliptic_curve_structs::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [3:0]   wr_addr,
    input  logic [31:0]  wr_data,
    input  logic [3:0]   rd_addr,
    output logic [31:0]  rd_data,
    output logic [95:0]  message,
    output logic [255:0] priv_key,
    output logic         core_reset,
    input  logic         core_done,
    input  logic         core_invalid,
    output logic         job_irq
);

    loader_state_e state_r;
    loader_state_e next_state_s;

    logic [31:0] key_r [8];
    logic [31:0] msg_r [3];
    logic        done_r;
    logic        invalid_r;
    logic        timeout_r;
    logic        wr_err_r;
    logic        first_run_r;
    logic        job_irq_r;
    logic [31:0] rd_data_r;
    logic [31:0] rd_next_s;
    logic [31:0] count_s;

    logic run_s;
    logic start_ok_s;
    logic clear_s;
    logic key_wr_s;
    logic msg_wr_s;
    logic done_hit_s;
    logic timeout_hit_s;
    logic finish_s;

    assign run_s      = (state_r == LD_RUN);
    assign start_ok_s = wr_en && (wr_addr == ADDR_START) && wr_data[0] && !run_s;
    assign clear_s    = wr_en && (wr_addr == ADDR_STATUS);
    assign key_wr_s   = wr_en && (wr_addr <= ADDR_KEY_LAST);
    assign msg_wr_s   = wr_en && (wr_addr >= ADDR_MSG_FIRST) && (wr_addr <= ADDR_MSG_LAST);
    // the core is still coming out of reset during the first RUN cycle
    assign done_hit_s = run_s && !first_run_r && core_done;

`ifdef ECDSA_JOB_TIMEOUT_EN
    assign timeout_hit_s = run_s && !done_hit_s && (count_s >= (TIMEOUT_CYCLES - 32'd1));
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit_s         = 1'b0;
`endif

    assign finish_s = done_hit_s || timeout_hit_s;

    job_cycle_counter u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok_s),
        .en    (run_s),
        .count (count_s)
    );

    // next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            LD_IDLE: begin
                if (start_ok_s) next_state_s = LD_RUN;
                else            next_state_s = LD_IDLE;
            end
            LD_RUN: begin
                if (finish_s) next_state_s = LD_DONE;
                else          next_state_s = LD_RUN;
            end
            LD_DONE: begin
                if (start_ok_s)   next_state_s = LD_RUN;
                else if (clear_s) next_state_s = LD_IDLE;
                else              next_state_s = LD_DONE;
            end
            default: next_state_s = LD_IDLE;
        endcase
    end

    // state, completion pulse and first-cycle marker
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= LD_IDLE;
            job_irq_r   <= 1'b0;
            first_run_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            job_irq_r   <= finish_s;
            first_run_r <= start_ok_s;
        end
    end

    // status flags; completion beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            done_r    <= 1'b0;
            invalid_r <= 1'b0;
            timeout_r <= 1'b0;
            wr_err_r  <= 1'b0;
        end else begin
            if (start_ok_s) begin
                done_r    <= 1'b0;
                invalid_r <= 1'b0;
                timeout_r <= 1'b0;
            end else if (finish_s) begin
                done_r    <= 1'b1;
                invalid_r <= done_hit_s ? core_invalid : 1'b0;
                timeout_r <= !done_hit_s;
            end else if (clear_s && !run_s) begin
                done_r    <= 1'b0;
                invalid_r <= 1'b0;
                timeout_r <= 1'b0;
            end else begin
                done_r    <= done_r;
                invalid_r <= invalid_r;
                timeout_r <= timeout_r;
            end

            if ((key_wr_s || msg_wr_s) && run_s) wr_err_r <= 1'b1;
            else if (clear_s)                    wr_err_r <= 1'b0;
            else                                 wr_err_r <= wr_err_r;
        end
    end

    // operand words; writes while the core runs are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) key_r[i] <= 32'd0;
            for (int i = 0; i < 3; i++) msg_r[i] <= 32'd0;
        end else if (!run_s) begin
            if (key_wr_s) key_r[wr_addr[2:0]] <= wr_data;
            if (msg_wr_s) begin
                case (wr_addr)
                    ADDR_MSG_FIRST: msg_r[0] <= wr_data;
                    ADDR_MSG_MID:   msg_r[1] <= wr_data;
                    ADDR_MSG_LAST:  msg_r[2] <= wr_data;
                    default:        msg_r[0] <= msg_r[0];
                endcase
            end
        end
    end

    // read mux; key words are write-only
    always_comb begin
        rd_next_s = 32'd0;
        case (rd_addr)
            ADDR_MSG_FIRST: rd_next_s = msg_r[0];
            ADDR_MSG_MID:   rd_next_s = msg_r[1];
            ADDR_MSG_LAST:  rd_next_s = msg_r[2];
            ADDR_COUNT:     rd_next_s = count_s;
            ADDR_STATUS:    rd_next_s = pack_status(run_s, done_r, invalid_r, timeout_r, wr_err_r);
            default:        rd_next_s = 32'd0;
        endcase
    end

    // registered read port
    always_ff @(posedge clk) begin
        if (reset) rd_data_r <= 32'd0;
        else       rd_data_r <= rd_next_s;
    end

    assign rd_data    = rd_data_r;
    assign job_irq    = job_irq_r;
    assign core_reset = !run_s;
    assign message    = {msg_r[2], msg_r[1], msg_r[0]};
    assign priv_key   = {key_r[7], key_r[6], key_r[5], key_r[4],
                         key_r[3], key_r[2], key_r[1], key_r[0]};

endmodule

// File: tb/tb_ecdsa_job_loader.sv
// Self-checking bench for ecdsa_job_loader: register table, job sequences,
// write-error, reset and timeout corner cases with a read scoreboard.
module tb_ecdsa_job_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [3:0]   rd_addr;
    logic [31:0]  rd_data;
    logic [95:0]  message;
    logic [255:0] priv_key;
    logic         core_reset;
    logic         core_done;
    logic         core_invalid;
    logic         job_irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t         vecs [13];
    logic [255:0] exp_key;
    logic [95:0]  exp_msg;

    ecdsa_job_loader #(.TIMEOUT_CYCLES(32'd10)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .message      (message),
        .priv_key     (priv_key),
        .core_reset   (core_reset),
        .core_done    (core_done),
        .core_invalid (core_invalid),
        .job_irq      (job_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
        rd_addr = addr;
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    // advance to the next falling edge and retire any pending read
    task automatic step();
        @(negedge clk);
        if (exp_q.size() != 0) check(name_q.pop_front(), {224'd0, rd_data}, {224'd0, exp_q.pop_front()});
    endtask

    task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        step();
        wr_en = 1'b0;
    endtask

    task automatic start_job();
        write_reg(4'd14, 32'd1);
    endtask

    // full job: core_done arrives in RUN cycle wait_cyc+1
    task automatic run_job(input int wait_cyc, input logic inv, input logic glitch);
        start_job();
        check("run_core_reset", {255'd0, core_reset}, 256'd0);
        if (glitch) core_done = 1'b1;
        issue_read(4'd12, 32'd0, "restart_count");
        step();
        core_done = 1'b0;
        issue_read(4'd15, 32'h1, "run_status");
        for (int i = 2; i <= wait_cyc; i++) step();
        core_done = 1'b1;
        core_invalid = inv;
        step();
        core_done = 1'b0;
        core_invalid = 1'b0;
        check("irq_pulse", {255'd0, job_irq}, {255'd0, 1'b1});
        check("done_core_reset", {255'd0, core_reset}, {255'd0, 1'b1});
        step();
        check("irq_single", {255'd0, job_irq}, 256'd0);
        issue_read(4'd12, wait_cyc + 1, "job_count");
        step();
        issue_read(4'd15, inv ? 32'h6 : 32'h2, "job_status");
        step();
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'd0;
        rd_addr = 4'd0; core_done = 1'b0; core_invalid = 1'b0;

        for (int i = 0; i < 8; i++) vecs[i] = '{addr: 4'(i), data: 32'(i + 1), exp_rd: 32'd0};
        vecs[8]  = '{addr: 4'd8,  data: 32'hA,         exp_rd: 32'hA};
        vecs[9]  = '{addr: 4'd9,  data: 32'hB,         exp_rd: 32'hB};
        vecs[10] = '{addr: 4'd10, data: 32'hC,         exp_rd: 32'hC};
        vecs[11] = '{addr: 4'd11, data: 32'hDEAD_BEEF, exp_rd: 32'd0};
        vecs[12] = '{addr: 4'd13, data: 32'h1234_5678, exp_rd: 32'd0};
        for (int i = 0; i < 8; i++) exp_key[32*i +: 32] = 32'(i + 1);
        exp_msg = {32'hC, 32'hB, 32'hA};

        step(); step(); step();
        check("rst_core_reset", {255'd0, core_reset}, {255'd0, 1'b1});
        check("rst_irq", {255'd0, job_irq}, 256'd0);
        check("rst_rd_data", {224'd0, rd_data}, 256'd0);
        check("rst_key", priv_key, 256'd0);
        check("rst_msg", {160'd0, message}, 256'd0);
        reset = 1'b0;
        issue_read(4'd15, 32'd0, "idle_status");
        step();

        foreach (vecs[i]) begin
            write_reg(vecs[i].addr, vecs[i].data);
            issue_read(vecs[i].addr, vecs[i].exp_rd, "tbl_rd");
            step();
        end
        check("loaded_key", priv_key, exp_key);
        check("loaded_msg", {160'd0, message}, {160'd0, exp_msg});

        run_job(20, 1'b0, 1'b0);
        check("job_key", priv_key, exp_key);
        run_job(6, 1'b1, 1'b1);

        // wr_err during RUN, clear in RUN, then clear racing completion
        start_job();
        write_reg(4'd3, 32'hFFFF_FFFF);
        check("run_wr_dropped", priv_key, exp_key);
        issue_read(4'd15, 32'h11, "wr_err_status");
        step();
        write_reg(4'd15, 32'd0);
        issue_read(4'd15, 32'h1, "wr_err_cleared");
        step();
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'd0; core_done = 1'b1;
        step();
        wr_en = 1'b0; core_done = 1'b0;
        check("clr_race_irq", {255'd0, job_irq}, {255'd0, 1'b1});
        issue_read(4'd15, 32'h2, "clr_race_status");
        step();
        write_reg(4'd15, 32'd0);
        issue_read(4'd15, 32'h0, "done_to_idle");
        step();
        check("idle_core_reset", {255'd0, core_reset}, {255'd0, 1'b1});

        // reset 5 cycles into RUN with a concurrent key write
        start_job();
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h5555_5555;
        step();
        reset = 1'b0; wr_en = 1'b0;
        check("mid_rst_core_reset", {255'd0, core_reset}, {255'd0, 1'b1});
        check("mid_rst_irq", {255'd0, job_irq}, 256'd0);
        check("mid_rst_rd", {224'd0, rd_data}, 256'd0);
        check("mid_rst_key", priv_key, 256'd0);
        check("mid_rst_msg", {160'd0, message}, 256'd0);
        issue_read(4'd15, 32'd0, "mid_rst_status");
        step();
        issue_read(4'd8, 32'd0, "mid_rst_msg_rd");
        step();
        issue_read(4'd12, 32'd0, "mid_rst_count");
        step();

`ifdef ECDSA_JOB_TIMEOUT_EN
        start_job();
        for (int i = 0; i < 9; i++) step();
        check("to_not_yet", {255'd0, job_irq}, 256'd0);
        step();
        check("to_irq", {255'd0, job_irq}, {255'd0, 1'b1});
        issue_read(4'd15, 32'hA, "to_status");
        step();
        issue_read(4'd12, 32'd10, "to_count");
        step();
`else
        start_job();
        for (int i = 0; i < 14; i++) step();
        issue_read(4'd15, 32'h1, "no_to_busy");
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        issue_read(4'd15, 32'h2, "no_to_status");
        step();
`endif

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
